dmem_bridge: RTL

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge_if.sv | 45 ++++
 rtl/dmem_bridge.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dmem_bridge_if.sv
// Upstream data-memory port and downstream bus port of the dmem bridge.
// The bridge uses the slave view; the requester/bus-model side uses master.
interface dmem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  dmem_req;
  logic                  dmem_wr;
  logic                  dmem_ex;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W/8-1:0]   dmem_byte;
  logic [DATA_W-1:0]     dmem_wdata;
  logic [DATA_W-1:0]     dmem_rdata;
  logic [1:0]            dmem_bad;
  logic                  dmem_xstate;
  logic                  dmem_busy;
  logic                  pg_fault;
  logic                  resv_clr;

  logic                  bus_valid;
  logic                  bus_ready;
  logic [ADDR_W-1:0]     bus_addr;
  logic                  bus_wr;
  logic [DATA_W/8-1:0]   bus_byte;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_rvalid;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_rerr;

  modport slave (
    input  dmem_req, dmem_wr, dmem_ex, dmem_addr, dmem_byte, dmem_wdata,
    input  pg_fault, resv_clr,
    output dmem_rdata, dmem_bad, dmem_xstate, dmem_busy,
    output bus_valid, bus_addr, bus_wr, bus_byte, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata, bus_rerr
  );

  modport master (
    output dmem_req, dmem_wr, dmem_ex, dmem_addr, dmem_byte, dmem_wdata,
    output pg_fault, resv_clr,
    input  dmem_rdata, dmem_bad, dmem_xstate, dmem_busy,
    input  bus_valid, bus_addr, bus_wr, bus_byte, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata, bus_rerr
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: one outstanding bus transaction, page-fault short cut,
// and an LR/SC reservation tracked at bus-word granularity.
//
// state | meaning
// IDLE  | no transaction, ready to accept
// ISSUE | bus_valid held with registered payload until bus_ready
// WAIT  | waiting for bus_rvalid
// DONE  | one-cycle response to the requester; may accept again
module dmem_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input logic          clk,
  input logic          rstn,
  dmem_bridge_if.slave dif
);
  localparam int BE_W = DATA_W / 8;
  localparam int LSB  = $clog2(BE_W);
  localparam int GR_W = ADDR_W - LSB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic              ex_q;
  logic [BE_W-1:0]   byte_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        bad_q;
  logic              xstate_q;
  logic              resv_vld_q;
  logic [GR_W-1:0]   resv_gran_q;

  logic busy;
  logic accept;
  logic sc_req;
  logic resv_hit;
  logic fast_done;
  logic rsp;

  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign accept    = dif.dmem_req && !busy;
  assign sc_req    = dif.dmem_wr && dif.dmem_ex;
  assign resv_hit  = resv_vld_q && (resv_gran_q == dif.dmem_addr[ADDR_W-1:LSB]);
  // Faults and reservation-less SCs answer without touching the bus.
  assign fast_done = dif.pg_fault || (sc_req && !resv_hit);
  assign rsp       = (state_q == S_WAIT) && dif.bus_rvalid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) state_d = fast_done ? S_DONE : S_ISSUE;
      end
      S_ISSUE: if (dif.bus_ready)  state_d = S_WAIT;
      S_WAIT:  if (dif.bus_rvalid) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      ex_q    <= 1'b0;
      byte_q  <= '0;
      wdata_q <= '0;
    end else if (accept && !fast_done) begin
      addr_q  <= dif.dmem_addr;
      wr_q    <= dif.dmem_wr;
      ex_q    <= dif.dmem_ex;
      byte_q  <= dif.dmem_byte;
      wdata_q <= dif.dmem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q  <= '0;
      bad_q    <= 2'b00;
      xstate_q <= 1'b0;
    end else if (accept && fast_done) begin
      bad_q    <= {1'b0, dif.pg_fault};
      xstate_q <= 1'b0;
    end else if (rsp) begin
      rdata_q  <= dif.bus_rdata;
      bad_q    <= {dif.bus_rerr, 1'b0};
      xstate_q <= wr_q && ex_q && !dif.bus_rerr;
    end
  end

  // resv_clr wins over everything, including an LR completing this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resv_vld_q  <= 1'b0;
      resv_gran_q <= '0;
    end else if (dif.resv_clr) begin
      resv_vld_q  <= 1'b0;
    end else if (accept && sc_req) begin
      resv_vld_q  <= 1'b0;
    end else if (rsp && ex_q && !wr_q && !dif.bus_rerr) begin
      resv_vld_q  <= 1'b1;
      resv_gran_q <= addr_q[ADDR_W-1:LSB];
    end else if (rsp && wr_q && !ex_q && (resv_gran_q == addr_q[ADDR_W-1:LSB])) begin
      resv_vld_q  <= 1'b0;
    end
  end

  assign dif.dmem_busy   = busy;
  assign dif.dmem_rdata  = rdata_q;
  assign dif.dmem_bad    = (state_q == S_DONE) ? bad_q : 2'b00;
  assign dif.dmem_xstate = (state_q == S_DONE) && xstate_q;

  assign dif.bus_valid = (state_q == S_ISSUE);
  assign dif.bus_addr  = {addr_q[ADDR_W-1:LSB], {LSB{1'b0}}};
  assign dif.bus_wr    = wr_q;
  assign dif.bus_byte  = byte_q;
  assign dif.bus_wdata = wdata_q;
endmodule
